// File: rtl/quant_pipe_mc.sv
// Multi-lane, multi-channel requantiser: signed ACC_W accumulators -> uint8 activations.
// Four-stage pipeline (sat16 / multiply / round-shift / clamp+zp) with a per-channel
// scale/shift/zero-point table addressed by an internal channel counter.
// Optional feature macro: QUANT_RELU_EN (clamps negative int8 results to 0 before the zp add).
module quant_pipe_mc #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned CH_NUM = 16,
  parameter int unsigned CH_AW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [CH_AW-1:0]         cfg_addr,
  input  logic [15:0]              cfg_scale,
  input  logic [3:0]               cfg_shift,
  input  logic [7:0]               cfg_zp,
  input  logic                     ch_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*8-1:0]       out_data,
  output logic [CH_AW-1:0]         out_ch
);

  localparam logic signed [ACC_W-1:0] AccMax = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] AccMin = ACC_W'(-32'sd32768);
  localparam logic signed [32:0]      RMax   = 33'sd127;
  localparam logic signed [32:0]      RMin   = -33'sd128;

  logic signed [15:0] tbl_scale_q [CH_NUM];
  logic [3:0]         tbl_shift_q [CH_NUM];
  logic [7:0]         tbl_zp_q    [CH_NUM];
  logic [CH_AW-1:0]   ch_q;

  logic adv, accept;

  logic               s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [15:0] s1_sat_d  [LANES];
  logic signed [15:0] s1_sat_q  [LANES];
  logic signed [15:0] s1_scale_q;
  logic [3:0]         s1_shift_q, s2_shift_q;
  logic [7:0]         s1_zp_q, s2_zp_q, s3_zp_q;
  logic [CH_AW-1:0]   s1_ch_q, s2_ch_q, s3_ch_q;
  logic signed [31:0] s2_prod_d [LANES];
  logic signed [31:0] s2_prod_q [LANES];
  logic signed [32:0] s3_r_d    [LANES];
  logic signed [32:0] s3_r_q    [LANES];
  logic [LANES*8-1:0] out_data_d;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > AccMax) return 16'sh7fff;
    else if (a < AccMin) return 16'sh8000;
    else return a[15:0];
  endfunction

  // Round half up: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [32:0] round_shift(input logic signed [31:0] p,
                                                     input logic [3:0] sh);
    logic signed [32:0] bias;
    bias = 33'sd1 <<< (sh - 4'd1);
    if (sh == 4'd0) return 33'(p);
    return (33'(p) + bias) >>> sh;
  endfunction

  function automatic logic [7:0] requant(input logic signed [32:0] r, input logic [7:0] zp);
    logic signed [7:0] q;
    if (r > RMax) q = 8'sd127;
    else if (r < RMin) q = -8'sd128;
    else q = r[7:0];
`ifdef QUANT_RELU_EN
    if (q < 0) q = '0;
`endif
    return q + zp;  // wraps mod 256 by design
  endfunction

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    accept   = in_valid && adv;
  end

  // Per-lane datapath for each stage boundary.
  always_comb begin
    out_data_d = '0;
    for (int l = 0; l < LANES; l++) begin
      s1_sat_d[l]  = sat16($signed(in_data[l*ACC_W +: ACC_W]));
      s2_prod_d[l] = 32'(s1_sat_q[l]) * 32'(s1_scale_q);
      s3_r_d[l]    = round_shift(s2_prod_q[l], s2_shift_q);
      out_data_d[l*8 +: 8] = requant(s3_r_q[l], s3_zp_q);
    end
  end

  // Parameter table and channel counter; beats read the table before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        tbl_scale_q[c] <= 16'sd1;
        tbl_shift_q[c] <= '0;
        tbl_zp_q[c]    <= '0;
      end
      ch_q <= '0;
    end else begin
      if (cfg_we && (32'(cfg_addr) < CH_NUM)) begin
        tbl_scale_q[cfg_addr] <= cfg_scale;
        tbl_shift_q[cfg_addr] <= cfg_shift;
        tbl_zp_q[cfg_addr]    <= cfg_zp;
      end
      if (ch_clr) begin
        ch_q <= '0;
      end else if (accept && in_last) begin
        ch_q <= (ch_q == CH_AW'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;
      end
    end
  end

  // Pipeline registers S1..S4 (S4 is the output register).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      s1_scale_q <= '0;
      s1_shift_q <= '0;
      s2_shift_q <= '0;
      s1_zp_q    <= '0;
      s2_zp_q    <= '0;
      s3_zp_q    <= '0;
      s1_ch_q    <= '0;
      s2_ch_q    <= '0;
      s3_ch_q    <= '0;
      out_ch     <= '0;
      out_data   <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_sat_q[l]  <= '0;
        s2_prod_q[l] <= '0;
        s3_r_q[l]    <= '0;
      end
    end else if (adv) begin
      s1_valid_q <= accept;
      s1_scale_q <= tbl_scale_q[ch_q];
      s1_shift_q <= tbl_shift_q[ch_q];
      s1_zp_q    <= tbl_zp_q[ch_q];
      s1_ch_q    <= ch_q;
      s2_valid_q <= s1_valid_q;
      s2_shift_q <= s1_shift_q;
      s2_zp_q    <= s1_zp_q;
      s2_ch_q    <= s1_ch_q;
      s3_valid_q <= s2_valid_q;
      s3_zp_q    <= s2_zp_q;
      s3_ch_q    <= s2_ch_q;
      out_valid  <= s3_valid_q;
      out_ch     <= s3_ch_q;
      out_data   <= out_data_d;
      for (int l = 0; l < LANES; l++) begin
        s1_sat_q[l]  <= s1_sat_d[l];
        s2_prod_q[l] <= s2_prod_d[l];
        s3_r_q[l]    <= s3_r_d[l];
      end
    end
  end

endmodule

// File: tb/tb_quant_pipe_mc.sv
// Bench for quant_pipe_mc: fixed vectors, channel sweep, random backpressure,
// config/beat race and mid-stream reset, all checked against a scoreboard model.
module tb_quant_pipe_mc;

  localparam int LANES  = 4;
  localparam int ACC_W  = 18;
  localparam int CH_NUM = 16;
  localparam int CH_AW  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cfg_we;
  logic [CH_AW-1:0]       cfg_addr;
  logic [15:0]            cfg_scale;
  logic [3:0]             cfg_shift;
  logic [7:0]             cfg_zp;
  logic                   ch_clr;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*8-1:0]     out_data;
  logic [CH_AW-1:0]       out_ch;

  quant_pipe_mc #(.LANES(LANES), .ACC_W(ACC_W), .CH_NUM(CH_NUM), .CH_AW(CH_AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .ch_clr(ch_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_scale [CH_NUM];
  int m_shift [CH_NUM];
  int m_zp    [CH_NUM];
  int m_ch;
  int cur_acc [LANES];
  logic [LANES*8-1:0] exp_data_q[$];
  int                 exp_ch_q[$];
  logic [LANES*8-1:0] rx_log[$];
  int rx_count  = 0;
  int acc_count = 0;
  logic               prev_stall = 1'b0;
  logic [LANES*8-1:0] prev_data;
  logic [CH_AW-1:0]   prev_ch;

  typedef struct {
    int a0, a1, a2, a3;
    int scale, shift, zp;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requantise one accumulator from the arithmetic rules with plain integers.
  function automatic int quant(input int acc, input int scale, input int shift, input int zp);
    longint s, p, t, d, r, q;
    s = acc;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    p = s * scale;
    if (shift == 0) r = p;
    else begin
      d = longint'(1) << shift;
      t = p + d / 2;
      r = t / d;
      if ((t % d != 0) && (t < 0)) r = r - 1;  // floor division
    end
    q = r;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`ifdef QUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'((q + zp) & 255);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      m_scale[c] = 1;
      m_shift[c] = 0;
      m_zp[c]    = 0;
    end
    m_ch = 0;
  endfunction

  // One clock: observe at the negedge, update the model, return just after the posedge.
  task automatic tick();
    logic [LANES*8-1:0] e;
    @(negedge clk);
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, prev_data);
      check("stall_ch", out_ch, prev_ch);
    end
    if (out_valid && out_ready) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_out", 1'b1, 1'b0);
      end else begin
        check("out_data", out_data, exp_data_q.pop_front());
        check("out_ch", out_ch, exp_ch_q.pop_front());
      end
      rx_log.push_back(out_data);
      rx_count++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_ch    = out_ch;
    if (!rst_n) begin
      model_reset();
      exp_data_q.delete();
      exp_ch_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        for (int l = 0; l < LANES; l++)
          e[l*8 +: 8] = 8'(quant(cur_acc[l], m_scale[m_ch], m_shift[m_ch], m_zp[m_ch]));
        exp_data_q.push_back(e);
        exp_ch_q.push_back(m_ch);
        acc_count++;
      end
      if (ch_clr) m_ch = 0;
      else if (in_valid && in_ready && in_last) m_ch = (m_ch == CH_NUM - 1) ? 0 : m_ch + 1;
      if (cfg_we && int'(cfg_addr) < CH_NUM) begin
        m_scale[cfg_addr] = int'($signed(cfg_scale));
        m_shift[cfg_addr] = int'(cfg_shift);
        m_zp[cfg_addr]    = int'(cfg_zp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a0, input int a1, input int a2, input int a3);
    cur_acc[0] = a0; cur_acc[1] = a1; cur_acc[2] = a2; cur_acc[3] = a3;
    for (int l = 0; l < LANES; l++) in_data[l*ACC_W +: ACC_W] = ACC_W'(cur_acc[l]);
  endtask

  task automatic set_rand_beat();
    set_beat(int'($urandom_range(262143)) - 131072, int'($urandom_range(262143)) - 131072,
             int'($urandom_range(600)) - 300, int'($urandom_range(65535)) - 32768);
  endtask

  task automatic set_cfg(input int addr, input int scale, input int shift, input int zp);
    cfg_we    = 1'b1;
    cfg_addr  = CH_AW'(addr);
    cfg_scale = 16'(scale);
    cfg_shift = 4'(shift);
    cfg_zp    = 8'(zp);
  endtask

  task automatic idle();
    cfg_we = 1'b0; ch_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    idle();
    for (int n = 0; n < 300 && exp_data_q.size() != 0; n++) begin
      out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      tick();
    end
    check("drain_empty", 64'(exp_data_q.size()), 64'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int start, n;
    vecs[0] = '{5, -3, 0, 127, 1, 0, 0, 32'h7F00FD05};
    vecs[2] = '{100, 1, 2, 6, 3, 2, 0, 32'h0502014B};
`ifdef QUANT_RELU_EN
    vecs[1] = '{70000, -70000, 128, -129, 1, 0, 0, 32'h007F007F};
    vecs[3] = '{-5, 3, -1, 7, 1, 1, 10, 32'h0E0A0C0A};
    vecs[4] = '{100, -100, 0, 127, 1, 0, 200, 32'h47C8C82C};
    vecs[5] = '{10, -10, 64, -64, -2, 0, 0, 32'h7F001400};
    vecs[6] = '{32767, -32768, 1, 20000, 32767, 15, 0, 32'h7F01007F};
`else
    vecs[1] = '{70000, -70000, 128, -129, 1, 0, 0, 32'h807F807F};
    vecs[3] = '{-5, 3, -1, 7, 1, 1, 10, 32'h0E0A0C08};
    vecs[4] = '{100, -100, 0, 127, 1, 0, 200, 32'h47C8642C};
    vecs[5] = '{10, -10, 64, -64, -2, 0, 0, 32'h7F8014EC};
    vecs[6] = '{32767, -32768, 1, 20000, 32767, 15, 0, 32'h7F01807F};
`endif

    rst_n = 1'b0; out_ready = 1'b1; cfg_addr = '0; cfg_scale = '0; cfg_shift = '0; cfg_zp = '0;
    idle();
    set_beat(0, 0, 0, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ch", out_ch, '0);
    check("rst_in_ready", in_ready, 1'b1);

    // Vector 0 uses the reset table directly; the rest rewrite channel 0 first.
    for (int v = 0; v < 7; v++) begin
      idle();
      if (v != 0) set_cfg(0, vecs[v].scale, vecs[v].shift, vecs[v].zp);
      ch_clr = 1'b1;
      tick();
      idle();
      set_beat(vecs[v].a0, vecs[v].a1, vecs[v].a2, vecs[v].a3);
      in_valid = 1'b1;
      tick();
      idle();
      start = rx_count;
      n = 0;
      while (n < 10 && rx_count == start) begin
        tick();
        n++;
      end
      check($sformatf("vec%0d_latency", v), 64'(n), 64'd4);
      check($sformatf("vec%0d_data", v), rx_log[rx_log.size() - 1], 64'(vecs[v].exp));
    end

    // Channel sweep: every beat ends a channel; 17 beats wrap back to channel 0.
    idle();
    set_cfg(0, 1, 0, 1);
    tick();
    set_cfg(15, 1, 0, 7);
    ch_clr = 1'b1;
    tick();
    idle();
    start = rx_count;
    for (int b = 0; b < 17; b++) begin
      set_beat(b, -b, 2 * b, 100);
      in_valid = 1'b1; in_last = 1'b1;
      tick();
    end
    drain(1'b0);
    check("sweep_count", 64'(rx_count - start), 64'd17);

    // ch_clr together with a last beat: that beat keeps its channel, next one is channel 0.
    idle();
    set_beat(7, 7, 7, 7);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    ch_clr = 1'b1;
    tick();
    ch_clr = 1'b0;
    in_last = 1'b0;
    tick();
    drain(1'b0);

    // Random table, random traffic and 50% backpressure.
    idle();
    for (int c = 0; c < CH_NUM; c++) begin
      set_cfg(c, int'($urandom_range(65535)) - 32768, int'($urandom_range(15)),
              int'($urandom_range(255)));
      tick();
    end
    idle();
    ch_clr = 1'b1;
    tick();
    ch_clr = 1'b0;
    start = rx_count;
    acc_count = 0;
    for (int n2 = 0; n2 < 400 && acc_count < 20; n2++) begin
      set_rand_beat();
      in_valid  = 1'($urandom_range(1));
      in_last   = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      tick();
    end
    check("rand_accepted", 64'(acc_count), 64'd20);
    drain(1'b1);
    check("rand_count", 64'(rx_count - start), 64'd20);

    // Table write in the same cycle as a channel-0 beat: old scale, then doubled.
    idle();
    set_cfg(0, 1, 0, 0);
    ch_clr = 1'b1;
    tick();
    idle();
    rx_log.delete();
    set_cfg(0, 2, 0, 0);
    set_beat(10, 20, -30, 40);
    in_valid = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    drain(1'b0);
`ifdef QUANT_RELU_EN
    check("race_old_scale", rx_log[0], 32'h2800140A);
    check("race_new_scale", rx_log[1], 32'h50002814);
`else
    check("race_old_scale", rx_log[0], 32'h28E2140A);
    check("race_new_scale", rx_log[1], 32'h50C42814);
`endif

    // Reset in the middle of a burst discards everything in flight.
    idle();
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_rand_beat();
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_out_ch", out_ch, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    for (int b = 0; b < 6; b++) begin
      tick();
      check("midrst_quiet", out_valid, 1'b0);
    end
    set_beat(1, 2, 3, 4);
    in_valid = 1'b1;
    tick();
    drain(1'b0);
    check("midrst_recover", rx_log[rx_log.size() - 1], 32'h04030201);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
